// File: rtl/game_event_gen.sv
// Round timer and hit-button event producer for the game FSM: 1 Hz tick countdown in BCD,
// expiry flag, and debounced single-cycle score pulses. Optional SCORE_COOLDOWN_EN limits scoring to one per tick.
module game_event_gen #(
  parameter int game_timer      = 30,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clkIn,
  input  logic       reset,
  input  logic       incrementClk,
  input  logic       game_active,
  input  logic       hit_btn,
  output logic       player_scored,
  output logic       timer_expired,
  output logic [3:0] time_tens,
  output logic [3:0] time_ones
);

  localparam logic [3:0]  TENS_INIT = 4'(game_timer / 10);
  localparam logic [3:0]  ONES_INIT = 4'(game_timer % 10);
  localparam logic [19:0] DEB_LAST  = 20'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, COUNTING, EXPIRED} state_t;

  state_t      r_state;
  logic        r_inc_s1, r_inc_s2, r_inc_s3;
  logic        r_hit_s1, r_hs, r_deb;
  logic [19:0] r_deb_cnt;
  logic        r_score_pend, r_scored, r_expired;
  logic [3:0]  r_tens, r_ones;
  logic        w_tick, w_accept, w_score_ok, w_cool_blk;

  // Third flop only remembers the previous synchronized level for edge detect.
  always_ff @(posedge clkIn or posedge reset) begin
    if (reset) begin
      r_inc_s1 <= 1'b0;
      r_inc_s2 <= 1'b0;
      r_inc_s3 <= 1'b0;
    end else begin
      r_inc_s1 <= incrementClk;
      r_inc_s2 <= r_inc_s1;
      r_inc_s3 <= r_inc_s2;
    end
  end

  assign w_tick = r_inc_s2 & ~r_inc_s3;

  always_ff @(posedge clkIn or posedge reset) begin
    if (reset) begin
      r_hit_s1  <= 1'b0;
      r_hs      <= 1'b0;
      r_deb     <= 1'b0;
      r_deb_cnt <= '0;
    end else begin
      r_hit_s1 <= hit_btn;
      r_hs     <= r_hit_s1;
      if (r_hs != r_deb) begin
        if (r_deb_cnt == DEB_LAST) begin
          r_deb     <= r_hs;
          r_deb_cnt <= '0;
        end else begin
          r_deb_cnt <= r_deb_cnt + 20'd1;
        end
      end else begin
        r_deb_cnt <= '0;
      end
    end
  end

  assign w_accept   = (r_hs != r_deb) && (r_deb_cnt == DEB_LAST);
  // State is judged on the edge the debounced level rises, so a hit landing with the final tick still counts.
  assign w_score_ok = w_accept && r_hs && (r_state == COUNTING) && !w_cool_blk;

`ifdef SCORE_COOLDOWN_EN
  logic r_cool;
  always_ff @(posedge clkIn or posedge reset) begin
    if (reset)                                r_cool <= 1'b0;
    else if (w_score_ok)                      r_cool <= 1'b1;
    else if (w_tick || r_state != COUNTING)   r_cool <= 1'b0;
  end
  assign w_cool_blk = r_cool;
`else
  assign w_cool_blk = 1'b0;
`endif

  always_ff @(posedge clkIn or posedge reset) begin
    if (reset) begin
      r_score_pend <= 1'b0;
      r_scored     <= 1'b0;
    end else begin
      r_score_pend <= w_score_ok;
      r_scored     <= r_score_pend;
    end
  end

  always_ff @(posedge clkIn or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_tens    <= TENS_INIT;
      r_ones    <= ONES_INIT;
      r_expired <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_tens    <= TENS_INIT;
          r_ones    <= ONES_INIT;
          r_expired <= 1'b0;
          if (game_active) r_state <= COUNTING;
        end
        COUNTING: begin
          if (!game_active) begin
            r_state <= IDLE;
            r_tens  <= TENS_INIT;
            r_ones  <= ONES_INIT;
          end else if (w_tick) begin
            if (r_tens == 4'd0 && r_ones == 4'd1) begin
              r_ones    <= 4'd0;
              r_expired <= 1'b1;
              r_state   <= EXPIRED;
            end else if (r_ones == 4'd0) begin
              r_ones <= 4'd9;
              r_tens <= r_tens - 4'd1;
            end else begin
              r_ones <= r_ones - 4'd1;
            end
          end
        end
        EXPIRED: begin
          if (!game_active) begin
            r_state   <= IDLE;
            r_expired <= 1'b0;
            r_tens    <= TENS_INIT;
            r_ones    <= ONES_INIT;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign player_scored = r_scored;
  assign timer_expired = r_expired;
  assign time_tens     = r_tens;
  assign time_ones     = r_ones;

endmodule

// File: tb/tb_game_event_gen.sv
// Scoreboard bench for game_event_gen: three instances (3 s, 12 s, 10 s rounds) share stimulus;
// expected output changes and score pulses are queued with their cycle and matched by a monitor.
module tb_game_event_gen;

  logic clk = 1'b0, rst = 1'b1, inc = 1'b0, act = 1'b0, hit = 1'b0;
  logic sc0, ex0, sc1, ex1, sc2, ex2;
  logic [3:0] t0, o0, t1, o1, t2, o2;
  int cyc = 0, nchk = 0, npass = 0;

  typedef struct {int ch; int cyc; logic [8:0] val;} ev_t;
  ev_t evq[$];
  logic [8:0] last [3];

  game_event_gen #(.game_timer(3), .DEBOUNCE_CYCLES(4)) dut (
    .clkIn(clk), .reset(rst), .incrementClk(inc), .game_active(act), .hit_btn(hit),
    .player_scored(sc0), .timer_expired(ex0), .time_tens(t0), .time_ones(o0));
  game_event_gen #(.game_timer(12), .DEBOUNCE_CYCLES(4)) dut12 (
    .clkIn(clk), .reset(rst), .incrementClk(inc), .game_active(act), .hit_btn(hit),
    .player_scored(sc1), .timer_expired(ex1), .time_tens(t1), .time_ones(o1));
  game_event_gen #(.game_timer(10), .DEBOUNCE_CYCLES(4)) dut10 (
    .clkIn(clk), .reset(rst), .incrementClk(inc), .game_active(act), .hit_btn(hit),
    .player_scored(sc2), .timer_expired(ex2), .time_tens(t2), .time_ones(o2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [8:0] act_v, input logic [8:0] exp_v);
    nchk++;
    if (act_v === exp_v) npass++;
    else $display("FAIL %s got=%h expected=%h", name, act_v, exp_v);
  endtask

  task automatic push(input int ch, input int c, input logic [8:0] v);
    ev_t e;
    e.ch = ch; e.cyc = c; e.val = v;
    evq.push_back(e);
  endtask

  // Channel 0..2: {expired, tens, ones} changes per instance; channel 3: score pulse on the 3 s instance.
  task automatic match(input int ch, input logic [8:0] v);
    int idx = -1;
    for (int i = 0; i < evq.size(); i++)
      if (idx < 0 && evq[i].ch == ch) idx = i;
    nchk++;
    if (idx < 0) begin
      $display("FAIL unexpected ch%0d cyc=%0d got=%h", ch, cyc, v);
    end else begin
      if (evq[idx].cyc == cyc && evq[idx].val === v) npass++;
      else $display("FAIL ch%0d got=%h@%0d expected=%h@%0d", ch, v, cyc, evq[idx].val, evq[idx].cyc);
      evq.delete(idx);
    end
  endtask

  always @(negedge clk) begin : mon
    logic [8:0] o [3];
    o[0] = {ex0, t0, o0};
    o[1] = {ex1, t1, o1};
    o[2] = {ex2, t2, o2};
    if (rst) begin
      for (int i = 0; i < 3; i++) last[i] = o[i];
    end else begin
      for (int i = 0; i < 3; i++)
        if (o[i] !== last[i]) begin
          match(i, o[i]);
          last[i] = o[i];
        end
      if (sc0 !== 1'b0) match(3, {8'd0, sc0});
    end
  end

  task automatic tick(input bit [2:0] m, input logic [8:0] e0, input logic [8:0] e1, input logic [8:0] e2);
    int c;
    inc = 1'b1; c = cyc;
    if (m[0]) push(0, c + 3, e0);
    if (m[1]) push(1, c + 3, e1);
    if (m[2]) push(2, c + 3, e2);
    repeat (5) @(negedge clk);
    inc = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic press(input int len, input bit scores);
    int c;
    hit = 1'b1; c = cyc;
    if (scores) push(3, c + 7, 9'h001);
    repeat (len) @(negedge clk);
    hit = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic deact();
    int c;
    act = 1'b0; c = cyc;
    push(0, c + 1, 9'h003);
    push(1, c + 1, 9'h012);
    push(2, c + 1, 9'h010);
    repeat (3) @(negedge clk);
  endtask

  task automatic rst_vals(input string tag);
    chk({tag, "_d3"},  {ex0, t0, o0}, 9'h003);
    chk({tag, "_d12"}, {ex1, t1, o1}, 9'h012);
    chk({tag, "_d10"}, {ex2, t2, o2}, 9'h010);
    chk({tag, "_sc"},  {6'd0, sc0, sc1, sc2}, 9'h000);
  endtask

  initial begin
    int c;
    repeat (3) @(negedge clk);
    rst_vals("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Full 3 s round, plus BCD borrow on the 12 s and 10 s instances.
    act = 1'b1;
    repeat (2) @(negedge clk);
    tick(3'b111, 9'h002, 9'h011, 9'h009);
    press(3, 1'b0);
    press(10, 1'b1);
    tick(3'b111, 9'h001, 9'h010, 9'h008);
    tick(3'b111, 9'h100, 9'h009, 9'h007);
    tick(3'b110, 9'h100, 9'h008, 9'h006);
    deact();

    // Held from IDLE into COUNTING must not score; a fresh press does.
    press(0, 1'b0);
    hit = 1'b1;
    repeat (8) @(negedge clk);
    act = 1'b1;
    repeat (5) @(negedge clk);
    hit = 1'b0;
    repeat (10) @(negedge clk);
    press(8, 1'b1);

    // Drop mid-count, then a tick colliding with game_active falling.
    tick(3'b111, 9'h002, 9'h011, 9'h009);
    deact();
    act = 1'b1;
    repeat (2) @(negedge clk);
    inc = 1'b1;
    repeat (2) @(negedge clk);
    act = 1'b0;
    repeat (4) @(negedge clk);
    inc = 1'b0;
    repeat (4) @(negedge clk);

    // Hit accepted on the same edge as the final tick.
    act = 1'b1;
    repeat (2) @(negedge clk);
    tick(3'b111, 9'h002, 9'h011, 9'h009);
    tick(3'b111, 9'h001, 9'h010, 9'h008);
    hit = 1'b1; c = cyc;
    push(3, c + 7, 9'h001);
    push(0, c + 6, 9'h100);
    push(1, c + 6, 9'h009);
    push(2, c + 6, 9'h007);
    repeat (3) @(negedge clk);
    inc = 1'b1;
    repeat (5) @(negedge clk);
    hit = 1'b0;
    repeat (3) @(negedge clk);
    inc = 1'b0;
    repeat (10) @(negedge clk);
    deact();

    // Two presses within one tick period, then one after a tick.
    act = 1'b1;
    repeat (2) @(negedge clk);
    press(8, 1'b1);
`ifdef SCORE_COOLDOWN_EN
    press(8, 1'b0);
`else
    press(8, 1'b1);
`endif
    tick(3'b111, 9'h002, 9'h011, 9'h009);
    press(8, 1'b1);

    // Asynchronous reset in the middle of a debounce.
    hit = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 rst_vals("midrst");
    @(negedge clk);
    hit = 1'b0;
    act = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);

    while (evq.size() > 0) begin
      nchk++;
      $display("FAIL missing ch%0d expected=%h@%0d", evq[0].ch, evq[0].val, evq[0].cyc);
      evq.delete(0);
    end
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
